ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter: AW, default 12, word-address width of the attached 4-byte-lane RAM; the byte address is AW+2 bits.
REQ-002 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  in  1  access request present.
REQ-005 Port: req_ready  out  1  controller idle and accepting a request.
REQ-006 Port: req_we  in  1  1 = store, 0 = load.
REQ-007 Port: req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 Port: req_signed  in  1  sign-extend the load result when 1.
REQ-009 Port: req_addr  in  AW+2  byte address.
REQ-010 Port: req_wdata  in  32  store data, right-justified.
REQ-011 Port: rsp_valid  out  1  one-cycle completion pulse for loads and stores.
REQ-012 Port: rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 Port: rsp_err  out  1  qualified by rsp_valid.
REQ-014 Port: mem_cs, mem_we[3:0], mem_addr[AW-1:0], mem_din[31:0]  out; mem_dout[31:0]  in  RAM side.

Function
REQ-015 The SHALL treat the RAM as synchronous: mem_dout reflects the word addressed with mem_cs=1 in the previous cycle, and reads 0 otherwise.
REQ-016 The FSM SHALL have the states IDLE, ACC1, ACC2 and DONE; req_ready SHALL be 1 only in IDLE.
REQ-017 The request SHALL be accepted in IDLE when req_valid=1, with all request fields registered, and the FSM SHALL then move to ACC1.
REQ-018 The byte mask m SHALL be 0001 for a byte, 0011 for a halfword and 1111 for a word, with offset off=req_addr[1:0], M[7:0]=m<<off, and misaligned defined as M[7:4]!=0.
REQ-019 ACC1 SHALL drive mem_cs=1, mem_addr=req_addr[AW+1:2], mem_we=M[3:0] for a store or 0000 for a load, and mem_din=D[31:0], where D[63:0]={32'b0,wdata}<<(8*off).
REQ-020 From ACC1 the FSM SHALL go to ACC2 when misaligned, else to DONE.
REQ-021 ACC2 SHALL drive mem_cs=1, mem_addr=first word address+1 (wrapping modulo 2^AW), mem_we=M[7:4] for a store, and mem_din=D[63:32]; it SHALL capture mem_dout as the low word.
REQ-022 DONE SHALL pulse rsp_valid for exactly one cycle and return to IDLE; mem_cs SHALL be 0 in IDLE and DONE.
REQ-023 Load data SHALL be R={hi,lo}>>(8*off), truncated to the access size, then sign-extended when req_signed=1 or zero-extended otherwise; for an aligned access, lo=mem_dout in DONE; for a misaligned access, hi=mem_dout in DONE.
REQ-024 Latency from the acceptance edge to rsp_valid SHALL be 2 cycles aligned and 3 cycles misaligned, with throughput of one request per 3 (or 4) cycles.
REQ-025 req_size=11 SHALL take the path IDLE->ACC1->DONE with mem_cs=0 and mem_we=0000, and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-026 Request inputs SHALL be ignored outside IDLE; req_valid arriving in DONE waits for IDLE.

Reset
REQ-027 While rst_n=0, the block SHALL hold state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_cs=0, mem_we=0000, mem_addr=0 and mem_din=0.
REQ-028 req_ready SHALL rise on the first clock edge after rst_n is released.
REQ-029 Reset mid-access SHALL abort immediately with no response; a first-word store already written SHALL NOT be rolled back.

Configuration
REQ-030 With MISALIGN_SPLIT_EN defined, a misaligned access SHALL be split per REQ-020..REQ-023.
REQ-031 Without MISALIGN_SPLIT_EN, a misaligned access SHALL be handled as in REQ-025 (no RAM access, rsp_err=1, rsp_rdata=0), the ACC2 state SHALL NOT exist, and latency SHALL always be 2.

Verification
REQ-032 Word store of 0xDEADBEEF to address 0x010, then signed word load from 0x010 -> mem_we=1111, mem_addr=4; load returns 0xDEADBEEF at acceptance+2.
REQ-033 Byte store of 0x80 to address 0x013, then signed byte load from 0x013 -> mem_we=1000 and mem_din[31:24]=0x80; load returns 0xFFFFFF80, and the unsigned load returns 0x00000080.
REQ-034 (MISALIGN_SPLIT_EN) Word store of 0x11223344 to address 0x006 -> ACC1 drives addr 1, we=1100, din=0x33440000; ACC2 drives addr 2, we=0011, din=0x00001122; a word load from 0x006 returns 0x11223344 at acceptance+3.
REQ-035 Halfword store to byte address 0x3FFF with AW=12 -> second access drives mem_addr=0 (wrap); without the macro, rsp_err=1 and mem_cs is never asserted.
REQ-036 req_size=11 load -> rsp_valid at acceptance+2 with rsp_err=1, rsp_rdata=0, and mem_cs=0 throughout.
REQ-037 rst_n asserted in ACC2 of a misaligned store -> all outputs 0 asynchronously, no rsp_valid, first-word bytes retain their written values, and req_ready=1 one edge after release.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: byte/halfword/word load-store front end for a 4-lane synchronous RAM.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two RAM cycles; otherwise they respond with an error.
module ram_access_ctrl #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW+1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          mem_cs,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
);
`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACC1, DONE} state_t;
`endif
    state_t state, nxt;
    logic up, we, sgn;
    logic [1:0] size, off;
    logic [AW+1:0] addr;
    logic [31:0] wdata, rw, ext;
    logic [4:0] sh;
    logic [3:0] m;
    logic [7:0] bm;
    logic mis, err;
`ifdef MISALIGN_SPLIT_EN
    logic [31:0] lo;
    logic [63:0] sd;
`else
    logic [31:0] sd;
`endif

    assign off = addr[1:0];
    assign sh = {off, 3'b000};
    assign m = (size == 2'b00) ? 4'b0001 : (size == 2'b01) ? 4'b0011 : 4'b1111;
    assign bm = {4'b0000, m} << off;
    assign mis = |bm[7:4];
`ifdef MISALIGN_SPLIT_EN
    assign err = size == 2'b11;
    assign sd = {32'b0, wdata} << sh;
    // Aligned loads take the word straight from the RAM in DONE; split loads pair it with the captured low word.
    assign rw = 32'({(mis ? mem_dout : 32'b0), (mis ? lo : mem_dout)} >> sh);
`else
    assign err = (size == 2'b11) || mis;
    assign sd = wdata << sh;
    assign rw = mem_dout >> sh;
`endif
    assign ext = (size == 2'b00) ? {{24{sgn & rw[7]}}, rw[7:0]} :
                 (size == 2'b01) ? {{16{sgn & rw[15]}}, rw[15:0]} : rw;
    // Held low through reset and for one edge after release.
    assign req_ready = up && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            up    <= 1'b0;
            we    <= 1'b0;
            sgn   <= 1'b0;
            size  <= 2'b00;
            addr  <= '0;
            wdata <= '0;
        end else begin
            up    <= 1'b1;
            state <= nxt;
            if (req_ready && req_valid) begin
                we    <= req_we;
                sgn   <= req_signed;
                size  <= req_size;
                addr  <= req_addr;
                wdata <= req_wdata;
            end
        end
    end

`ifdef MISALIGN_SPLIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lo <= '0;
        else if (state == ACC2) lo <= mem_dout;
    end
`endif

    always_comb begin
        nxt       = state;
        mem_cs    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_din   = '0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: nxt = (req_ready && req_valid) ? ACC1 : IDLE;
            ACC1: begin
`ifdef MISALIGN_SPLIT_EN
                nxt = (mis && !err) ? ACC2 : DONE;
`else
                nxt = DONE;
`endif
                if (!err) begin
                    mem_cs   = 1'b1;
                    mem_addr = addr[AW+1:2];
                    mem_we   = we ? bm[3:0] : 4'b0000;
                    mem_din  = sd[31:0];
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ACC2: begin
                nxt      = DONE;
                mem_cs   = 1'b1;
                mem_addr = addr[AW+1:2] + 1'b1;
                mem_we   = we ? bm[7:4] : 4'b0000;
                mem_din  = sd[63:32];
            end
`endif
            DONE: begin
                nxt       = IDLE;
                rsp_valid = 1'b1;
                rsp_err   = err;
                rsp_rdata = (err || we) ? 32'b0 : ext;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed table, corner sequences and randomized traffic against a byte-level memory model.
module tb_ram_access_ctrl;
    localparam int AW = 12;
    localparam int NB = 4 << AW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [AW+1:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err, mem_cs;
    logic [31:0] rsp_rdata, mem_din, mem_dout;
    logic [3:0] mem_we;
    logic [AW-1:0] mem_addr;

    ram_access_ctrl #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Synchronous RAM: filled on the first edge (held in reset), then read-old-data with lane writes.
    logic [31:0] ram [0:(1<<AW)-1];
    logic filled = 1'b0;
    always @(posedge clk) begin
        if (!filled) begin
            for (int w = 0; w < (1 << AW); w++) ram[w] <= init_word(w);
            filled <= 1'b1;
        end else if (mem_cs) begin
            for (int i = 0; i < 4; i++) if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
        end
        mem_dout <= mem_cs ? ram[mem_addr] : 32'b0;
    end

    logic [7:0] gold [0:NB-1];
    int n_vec = 0, n_bad = 0;
    int cs_cnt, lat, e_lat, e_ncs;
    logic err, e_err;
    logic [31:0] rd, e_rd;
    logic [AW-1:0] cap_addr [2];
    logic [3:0] cap_we [2];
    logic [31:0] cap_din [2];

    typedef struct {
        logic we; logic [1:0] sz; logic sg; logic [AW+1:0] a; logic [31:0] wd;
        logic err; logic [31:0] rd; int lat;
    } vec_t;
    vec_t tbl [8];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference: byte-addressed memory, access = n consecutive bytes wrapping over the whole space.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg, input logic [AW+1:0] a,
                         input logic [31:0] wd, output logic merr, output logic [31:0] mrd,
                         output int mlat, output int mncs);
        int n, off;
        logic mis;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        mis = (off + n) > 4;
`ifdef MISALIGN_SPLIT_EN
        merr = (sz == 2'd3);
`else
        merr = (sz == 2'd3) || mis;
`endif
        mlat = (mis && !merr) ? 3 : 2;
        mncs = merr ? 0 : (mis ? 2 : 1);
        mrd = '0;
        v = '0;
        if (!merr) begin
            for (int k = 0; k < n; k++) begin
                if (we) gold[(int'(a) + k) % NB] = wd[8*k +: 8];
                else v[8*k +: 8] = gold[(int'(a) + k) % NB];
            end
            if (!we) begin
                if (sg && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
                mrd = v;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg, input logic [AW+1:0] a,
                        input logic [31:0] wd, output int xlat, output logic xerr, output logic [31:0] xrd);
        int g = 0;
        logic got = 1'b0;
        @(negedge clk);
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        chk("ready_wait", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = (AW+2)'($urandom); req_wdata = $urandom;
        xlat = 0; xerr = 1'b0; xrd = '0; cs_cnt = 0;
        while (!got && xlat < 8) begin
            @(negedge clk);
            xlat++;
            if (mem_cs) begin
                if (cs_cnt < 2) begin cap_addr[cs_cnt] = mem_addr; cap_we[cs_cnt] = mem_we; cap_din[cs_cnt] = mem_din; end
                cs_cnt++;
            end
            if (rsp_valid) begin got = 1'b1; xerr = rsp_err; xrd = rsp_rdata; end
        end
        if (!got) chk("rsp_timeout", 0, 1);
        else begin @(negedge clk); chk("rsp_pulse_width", rsp_valid, 0); end
    endtask

    task automatic run(input logic we, input logic [1:0] sz, input logic sg, input logic [AW+1:0] a, input logic [31:0] wd);
        model(we, sz, sg, a, wd, e_err, e_rd, e_lat, e_ncs);
        xact(we, sz, sg, a, wd, lat, err, rd);
        chk("rnd_err", err, e_err);
        chk("rnd_rdata", rd, e_rd);
        chk("rnd_latency", lat, e_lat);
        chk("rnd_cs_cycles", cs_cnt, e_ncs);
    endtask

    task automatic chk_zero_outs();
        chk("rst_flags", {req_ready, rsp_valid, rsp_err, mem_cs, mem_we}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic rv;
        int c, c1, c2;
        for (int a = 0; a < NB; a++) begin w = init_word(a / 4); gold[a] = w[8*(a%4) +: 8]; end
        tbl[0] = '{1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2};
        tbl[1] = '{1'b0, 2'd2, 1'b1, 14'h010, 32'h0, 1'b0, 32'hDEADBEEF, 2};
        tbl[2] = '{1'b1, 2'd0, 1'b0, 14'h013, 32'h00000080, 1'b0, 32'h0, 2};
        tbl[3] = '{1'b0, 2'd0, 1'b1, 14'h013, 32'h0, 1'b0, 32'hFFFFFF80, 2};
        tbl[4] = '{1'b0, 2'd0, 1'b0, 14'h013, 32'h0, 1'b0, 32'h00000080, 2};
        tbl[5] = '{1'b0, 2'd1, 1'b1, 14'h012, 32'h0, 1'b0, 32'hFFFF80AD, 2};
        tbl[6] = '{1'b0, 2'd1, 1'b0, 14'h012, 32'h0, 1'b0, 32'h000080AD, 2};
        tbl[7] = '{1'b0, 2'd3, 1'b1, 14'h010, 32'h0, 1'b1, 32'h0, 2};

        repeat (3) @(negedge clk);
        chk_zero_outs();
        rst_n = 1'b1;
        #1 chk("ready_before_edge", req_ready, 0);
        @(posedge clk); #1 chk("ready_after_edge", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, e_err, e_rd, e_lat, e_ncs);
            xact(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, lat, err, rd);
            chk("tbl_err", err, tbl[i].err);
            chk("tbl_rdata", rd, tbl[i].rd);
            chk("tbl_latency", lat, tbl[i].lat);
            if (i == 0) begin
                chk("word_store_we", cap_we[0], 4'b1111);
                chk("word_store_addr", cap_addr[0], 4);
                chk("word_store_din", cap_din[0], 32'hDEADBEEF);
            end
            if (i == 2) begin
                chk("byte_store_we", cap_we[0], 4'b1000);
                chk("byte_store_din_lane3", cap_din[0][31:24], 8'h80);
            end
            if (i == 7) chk("illegal_size_cs", cs_cnt, 0);
        end

        model(1'b1, 2'd2, 1'b0, 14'h006, 32'h11223344, e_err, e_rd, e_lat, e_ncs);
        xact(1'b1, 2'd2, 1'b0, 14'h006, 32'h11223344, lat, err, rd);
`ifdef MISALIGN_SPLIT_EN
        chk("split_st_lat", lat, 3);
        chk("split_st_cs", cs_cnt, 2);
        chk("split_st_addr0", cap_addr[0], 1);
        chk("split_st_we0", cap_we[0], 4'b1100);
        chk("split_st_din0", cap_din[0], 32'h33440000);
        chk("split_st_addr1", cap_addr[1], 2);
        chk("split_st_we1", cap_we[1], 4'b0011);
        chk("split_st_din1", cap_din[1], 32'h00001122);
        model(1'b0, 2'd2, 1'b0, 14'h006, 32'h0, e_err, e_rd, e_lat, e_ncs);
        xact(1'b0, 2'd2, 1'b0, 14'h006, 32'h0, lat, err, rd);
        chk("split_ld_rdata", rd, 32'h11223344);
        chk("split_ld_lat", lat, 3);
        model(1'b1, 2'd1, 1'b0, 14'h3FFF, 32'h0000A55A, e_err, e_rd, e_lat, e_ncs);
        xact(1'b1, 2'd1, 1'b0, 14'h3FFF, 32'h0000A55A, lat, err, rd);
        chk("wrap_addr0", cap_addr[0], 12'hFFF);
        chk("wrap_addr1", cap_addr[1], 0);
        chk("wrap_err", err, 0);
`else
        chk("mis_st_err", err, 1);
        chk("mis_st_cs", cs_cnt, 0);
        chk("mis_st_lat", lat, 2);
        model(1'b1, 2'd1, 1'b0, 14'h3FFF, 32'h0000A55A, e_err, e_rd, e_lat, e_ncs);
        xact(1'b1, 2'd1, 1'b0, 14'h3FFF, 32'h0000A55A, lat, err, rd);
        chk("wrap_err", err, 1);
        chk("wrap_cs", cs_cnt, 0);
        chk("wrap_rdata", rd, 0);
`endif

        // Abort mid-access: reset lands after the first word has been written (split) or before any write.
        @(negedge clk);
        c = 0;
        while (!req_ready && c < 20) begin @(negedge clk); c++; end
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_wdata = 32'hAABBCCDD;
`ifdef MISALIGN_SPLIT_EN
        req_addr = 14'h007;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_acc2_we", {mem_cs, mem_we}, 5'b10111);
        gold[7] = 8'hDD;
`else
        req_addr = 14'h008;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_acc1_we", {mem_cs, mem_we}, 5'b11111);
`endif
        rst_n = 1'b0;
        #1 chk_zero_outs();
        rv = 1'b0;
        repeat (2) begin @(negedge clk); rv |= rsp_valid; end
        chk("abort_no_rsp", rv, 0);
        rst_n = 1'b1;
        #1 chk("abort_ready_before_edge", req_ready, 0);
        @(posedge clk); #1 chk("abort_ready_after_edge", req_ready, 1);
        run(1'b0, 2'd0, 1'b0, 14'h007, 32'h0);
        run(1'b0, 2'd2, 1'b0, 14'h008, 32'h0);

        // Back-to-back with req_valid held: second request must wait for IDLE.
        model(1'b1, 2'd2, 1'b0, 14'h020, 32'hCAFEF00D, e_err, e_rd, e_lat, e_ncs);
        model(1'b0, 2'd2, 1'b1, 14'h020, 32'h0, e_err, e_rd, e_lat, e_ncs);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 14'h020; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_we = 1'b0; req_signed = 1'b1; req_wdata = 32'h0;
        c = 0; c1 = 0; c2 = 0; rd = '0;
        while (c2 == 0 && c < 10) begin
            @(negedge clk);
            c++;
            if (c == 4) req_valid = 1'b0;
            if (rsp_valid) begin
                if (c1 == 0) c1 = c;
                else begin c2 = c; rd = rsp_rdata; end
            end
        end
        req_valid = 1'b0;
        chk("b2b_first_rsp", c1, 2);
        chk("b2b_second_rsp", c2, 5);
        chk("b2b_rdata", rd, e_rd);

        for (int i = 0; i < 300; i++)
            run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? 14'($urandom_range(0, 47)) : 14'($urandom_range(NB - 48, NB - 1)),
                $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
